mul_div_unit: RTL

- Multi-cycle signed 32-bit multiplier/divider; sits directly upstream of the HI and LO register instances.
- Multiply uses radix-2 Booth recoding. Divide uses restoring division on magnitudes with sign correction.
- Produces a 64-bit result split as hi/lo, plus a one-cycle done strobe that the control unit uses to raise HIin/LOin enables.
- Operands come from the bus-side Y register and the bus.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mul_div_step.sv | 63 ++++++
 rtl/mul_div_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the multiply/divide datapath.
// Latency: none (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of Booth multiply or restoring divide, selected by op.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module mul_div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_acc_hi,   // Booth P_hi, or partial remainder
  input  logic [WIDTH-1:0] i_acc_lo,   // Booth P_lo, or dividend/quotient shifter
  input  logic             i_q1,       // Booth q_-1 (unused when dividing)
  input  logic [WIDTH-1:0] i_mcand,    // signed multiplicand, or unsigned |divisor|
  output logic [WIDTH-1:0] o_acc_hi,
  output logic [WIDTH-1:0] o_acc_lo,
  output logic             o_q1
);

  logic [WIDTH:0] w_hi_ext;
  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_div_m;
  logic [WIDTH:0] w_trial;
  logic           w_qbit;

  // Single-step arithmetic; the Booth add/sub runs one bit wider so that a = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    w_hi_ext = {i_acc_hi[WIDTH-1], i_acc_hi};
    w_m_ext  = {i_mcand[WIDTH-1], i_mcand};
    w_sum    = w_hi_ext;
    w_shift  = {i_acc_hi, i_acc_lo[WIDTH-1]};
    w_div_m  = {1'b0, i_mcand};
    w_trial  = w_shift - w_div_m;
    w_qbit   = 1'b0;
    o_acc_hi = i_acc_hi;
    o_acc_lo = i_acc_lo;
    o_q1     = 1'b0;

    if (i_op == OP_MUL) begin
      case ({i_acc_lo[0], i_q1})
        2'b01:   w_sum = w_hi_ext + w_m_ext;
        2'b10:   w_sum = w_hi_ext - w_m_ext;
        default: w_sum = w_hi_ext;
      endcase
      // Arithmetic shift right of {sum, P_lo, q_-1}; the shifted sum always fits WIDTH bits.
      o_acc_hi = w_sum[WIDTH:1];
      o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
      o_q1     = i_acc_lo[0];
    end else begin
      // Remainder stays below |divisor|, so the shifted value fits WIDTH+1 bits and the
      // restored/subtracted remainder fits WIDTH bits.
      if (w_shift >= w_div_m) begin
        w_qbit   = 1'b1;
        o_acc_hi = w_trial[WIDTH-1:0];
      end else begin
        o_acc_hi = w_shift[WIDTH-1:0];
      end
      o_acc_lo = {i_acc_lo[WIDTH-2:0], w_qbit};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (Booth radix-2) / divide (restoring) feeding the HI/LO registers.
// Latency: done is high WIDTH edges after the start edge; divide-by-zero reports on the start edge itself.
// Backpressure: start is only honoured in IDLE or DONE; requests while busy are dropped.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic             r_sign_a;
  logic             r_neg_q;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_q1;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_dbz_req;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic             w_step_q1;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_dbz_req = (op == OP_DIV) && (b == '0);
  assign w_abs_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_abs_b   = b[WIDTH-1] ? (~b + 1'b1) : b;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .i_op     (r_op),
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_q1     (r_q1),
    .i_mcand  (r_mcand),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo),
    .o_q1     (w_step_q1)
  );

  // Sign fix-up of the final iteration: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    w_res_hi = w_step_hi;
    w_res_lo = w_step_lo;
    if (r_op == OP_DIV) begin
      w_res_lo = r_neg_q  ? (~w_step_lo + 1'b1) : w_step_lo;
      w_res_hi = r_sign_a ? (~w_step_hi + 1'b1) : w_step_hi;
    end
  end

  // State register; clr drops any operation in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status outputs; DONE accepts a new start exactly like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_dbz_req ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_dbz_req ? DONE : RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result registers; results only move on completion.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_sign_a <= 1'b0;
      r_neg_q  <= 1'b0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_q1     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= op;
      r_sign_a <= a[WIDTH-1];
      r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      r_acc_hi <= '0;
      r_q1     <= 1'b0;
      r_dbz    <= 1'b0;
      if (op == OP_MUL) begin
        r_mcand  <= a;
        r_acc_lo <= b;
      end else begin
        r_mcand  <= w_abs_b;
        r_acc_lo <= w_abs_a;
      end
      if (w_dbz_req) begin
        r_hi  <= a;
        r_lo  <= {WIDTH{1'b1}};
        r_dbz <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_cnt    <= r_cnt + 1'b1;
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      r_q1     <= w_step_q1;
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
